// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised RAM slice.
package ram_pkg;

   typedef enum logic {
      RAM_CLEAR = 1'b0,
      RAM_READY = 1'b1
   } ram_state_e;

   localparam int unsigned RDW_READ_FIRST  = 0;
   localparam int unsigned RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_core.sv
// Storage array with one write port and one registered read port.
module ram_core
   import ram_pkg::*;
#(
   parameter int DATA_W   = 4,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 32,
   parameter int RDW_MODE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic              rzero,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              bypass;

   assign bypass = (RDW_MODE == RDW_WRITE_FIRST) && we && (waddr == raddr);

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // rzero forces a zero word for reads the top flagged as out of range
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         if (rzero) begin
            rdata <= '0;
         end else if (bypass) begin
            rdata <= wdata;
         end else begin
            rdata <= mem[raddr];
         end
      end
   end

endmodule

// File: rtl/param_ram.sv
// Dual-port RAM top: clear-sweep FSM, write muxing, range checks, output stage.
module param_ram
   import ram_pkg::*;
#(
   parameter int              DATA_W    = 4,
   parameter int              ADDR_W    = 5,
   parameter int              DEPTH     = 2**ADDR_W,
   parameter int              OUT_REG   = 0,
   parameter int              RDW_MODE  = 0,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              clr_start,
   output logic              ready,
   output logic [DATA_W-1:0] dout,
   output logic              rd_valid,
   output logic              rd_err
);

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   ram_state_e        state, next_state;
   logic              sweep;
   logic [ADDR_W-1:0] ptr;

   logic              wr_ok, rd_fire, rd_oor;
   logic              core_we;
   logic [ADDR_W-1:0] core_waddr;
   logic [DATA_W-1:0] core_wdata, core_rdata;
   logic              v1, e1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RAM_CLEAR;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         RAM_CLEAR: if (ptr == LAST) next_state = RAM_READY;
         RAM_READY: if (clr_start)   next_state = RAM_CLEAR;
         default:   next_state = RAM_CLEAR;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      sweep = 1'b0;
      case (state)
         RAM_CLEAR: sweep = 1'b1;
         RAM_READY: ready = 1'b1;
         default:   sweep = 1'b1;
      endcase
   end

   // pointer parks at 0 outside the sweep so a new sweep always starts there
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (sweep && ptr != LAST) begin
         ptr <= ptr + 1'b1;
      end else begin
         ptr <= '0;
      end
   end

   assign wr_ok   = ready && wr_en && ({1'b0, wr_addr} < DEPTH_L);
   assign rd_fire = ready && rd_en;
   assign rd_oor  = ({1'b0, rd_addr} >= DEPTH_L);

   assign core_we    = sweep || wr_ok;
   assign core_waddr = sweep ? ptr : wr_addr;
   assign core_wdata = sweep ? CLEAR_VAL : wr_data;

   ram_core #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RDW_MODE (RDW_MODE)
   ) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (core_we),
      .waddr (core_waddr),
      .wdata (core_wdata),
      .re    (rd_fire),
      .rzero (rd_oor),
      .raddr (rd_addr),
      .rdata (core_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         e1 <= 1'b0;
      end else begin
         v1 <= rd_fire;
         e1 <= rd_fire && rd_oor;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic              v2, e2;
         logic [DATA_W-1:0] dq;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v2 <= 1'b0;
               e2 <= 1'b0;
               dq <= '0;
            end else begin
               v2 <= v1;
               e2 <= e1;
               if (v1) begin
                  dq <= core_rdata;
               end
            end
         end

         assign dout     = dq;
         assign rd_valid = v2;
         assign rd_err   = e2;
      end else begin : g_noreg
         assign dout     = core_rdata;
         assign rd_valid = v1;
         assign rd_err   = e1;
      end
   endgenerate

endmodule

// File: tb/tb_param_ram.sv
// Two param_ram configurations on shared stimulus, each checked against a queue-free time-slot model.
module tb_param_ram;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en, rd_en, clr_start;
   logic [4:0] wr_addr, rd_addr;
   logic [3:0] wr_data;

   logic [1:0] rdy, vld, err;
   logic [3:0] dout_w [2];

   always #5 clk = ~clk;

   param_ram #(
      .DATA_W (4), .ADDR_W (5), .DEPTH (32), .OUT_REG (0), .RDW_MODE (0), .CLEAR_VAL (4'h0)
   ) u_a (
      .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .rd_en (rd_en), .rd_addr (rd_addr), .clr_start (clr_start),
      .ready (rdy[0]), .dout (dout_w[0]), .rd_valid (vld[0]), .rd_err (err[0])
   );

   param_ram #(
      .DATA_W (4), .ADDR_W (5), .DEPTH (20), .OUT_REG (1), .RDW_MODE (1), .CLEAR_VAL (4'h5)
   ) u_b (
      .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .rd_en (rd_en), .rd_addr (rd_addr), .clr_start (clr_start),
      .ready (rdy[1]), .dout (dout_w[1]), .rd_valid (vld[1]), .rd_err (err[1])
   );

   int         depth_p [2] = '{32, 20};
   int         oreg_p  [2] = '{0, 1};
   int         rdw_p   [2] = '{0, 1};
   logic [3:0] cval_p  [2] = '{4'h0, 4'h5};

   // reference model: contents, remaining sweep edges, responses keyed by due edge
   logic [3:0] mem_m   [2][32];
   int         busy    [2];
   logic       sl_v    [2][4];
   logic [3:0] sl_d    [2][4];
   logic       sl_e    [2][4];
   logic [3:0] exp_dout[2];
   logic       exp_vld [2];
   logic       exp_err [2];
   int         cyc;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         busy[i]     = depth_p[i];
         exp_dout[i] = '0;
         exp_vld[i]  = 1'b0;
         exp_err[i]  = 1'b0;
         for (int s = 0; s < 4; s++) sl_v[i][s] = 1'b0;
      end
   endtask

   task automatic model_edge(input int i);
      logic [3:0] d;
      logic       e;
      int         due;
      if (busy[i] == 0) begin
         if (rd_en) begin
            e = (int'(rd_addr) >= depth_p[i]);
            if (e) d = '0;
            else if (rdw_p[i] == 1 && wr_en && wr_addr == rd_addr) d = wr_data;
            else d = mem_m[i][rd_addr];
            due = (cyc + oreg_p[i]) % 4;
            sl_v[i][due] = 1'b1;
            sl_d[i][due] = d;
            sl_e[i][due] = e;
         end
         if (wr_en && int'(wr_addr) < depth_p[i]) mem_m[i][wr_addr] = wr_data;
         if (clr_start) busy[i] = depth_p[i];
      end else begin
         mem_m[i][depth_p[i] - busy[i]] = cval_p[i];
         busy[i]--;
      end
      if (sl_v[i][cyc % 4]) begin
         exp_vld[i]  = 1'b1;
         exp_err[i]  = sl_e[i][cyc % 4];
         exp_dout[i] = sl_d[i][cyc % 4];
         sl_v[i][cyc % 4] = 1'b0;
      end else begin
         exp_vld[i] = 1'b0;
         exp_err[i] = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) model_edge(i);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("u%0d.ready", i),    32'(rdy[i]),    32'(busy[i] == 0));
         check($sformatf("u%0d.rd_valid", i), 32'(vld[i]),    32'(exp_vld[i]));
         check($sformatf("u%0d.rd_err", i),   32'(err[i]),    32'(exp_err[i]));
         check($sformatf("u%0d.dout", i),     32'(dout_w[i]), 32'(exp_dout[i]));
      end
   endtask

   task automatic drv(input logic we, input logic [4:0] wa, input logic [3:0] wd,
                      input logic re, input logic [4:0] ra, input logic clr);
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_en = re; rd_addr = ra; clr_start = clr;
      tick();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drv(1'b0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset();
      wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0;
      rst_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("u%0d.rst_ready", i), 32'(rdy[i]),    32'd0);
         check($sformatf("u%0d.rst_valid", i), 32'(vld[i]),    32'd0);
         check($sformatf("u%0d.rst_err", i),   32'(err[i]),    32'd0);
         check($sformatf("u%0d.rst_dout", i),  32'(dout_w[i]), 32'd0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic ready_edges();
      int ea, eb;
      ea = 0; eb = 0;
      wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (rdy[1] && eb == 0) eb = k;
         if (rdy[0] && ea == 0) ea = k;
         if (ea != 0 && eb != 0) break;
      end
      check("u0.ready_edge", 32'(ea), 32'd32);
      check("u1.ready_edge", 32'(eb), 32'd20);
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 40; k++) begin
         if (busy[0] == 0 && busy[1] == 0) break;
         idle(1);
      end
   endtask

   initial begin
      cyc = 0;
      do_reset();

      // reset and sweep, then read address 7
      ready_edges();
      wait_ready();
      drv(1'b0, '0, '0, 1'b1, 5'd7, 1'b0);
      idle(3);

      // write then back-to-back reads
      drv(1'b1, 5'd3,  4'd4, 1'b0, '0, 1'b0);
      drv(1'b1, 5'd7,  4'd8, 1'b0, '0, 1'b0);
      drv(1'b1, 5'd12, 4'd2, 1'b0, '0, 1'b0);
      drv(1'b0, '0, '0, 1'b1, 5'd3,  1'b0);
      drv(1'b0, '0, '0, 1'b1, 5'd7,  1'b0);
      drv(1'b0, '0, '0, 1'b1, 5'd12, 1'b0);
      idle(3);

      // read-during-write on the same address
      drv(1'b1, 5'd9, 4'd5,  1'b0, '0,   1'b0);
      drv(1'b1, 5'd9, 4'd11, 1'b1, 5'd9, 1'b0);
      drv(1'b0, '0, '0,      1'b1, 5'd9, 1'b0);
      idle(3);

      // clear during traffic
      for (int a = 0; a < 32; a++) drv(1'b1, 5'(a), 4'hF, 1'b0, '0, 1'b0);
      drv(1'b0, '0, '0, 1'b1, 5'd2, 1'b1);
      wait_ready();
      for (int a = 0; a < 32; a++) drv(1'b0, '0, '0, 1'b1, 5'(a), 1'b0);
      idle(3);

      // out-of-range accesses (beyond DEPTH of the second instance)
      drv(1'b1, 5'd25, 4'd6, 1'b0, '0,    1'b0);
      drv(1'b0, '0, '0,      1'b1, 5'd25, 1'b0);
      drv(1'b0, '0, '0,      1'b1, 5'd5,  1'b0);
      idle(3);

      // reset mid-sweep
      do_reset();
      idle(9);
      do_reset();
      ready_edges();
      wait_ready();

      // randomized traffic with occasional clear sweeps
      for (int n = 0; n < 3000; n++) begin
         drv(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 99) == 0));
      end
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
